// File: rtl/cphy_tx_pkg.sv
// C-PHY TX lane shared definitions: wire states, driver codes, FSM states,
// LP line codes and the fixed sync word.
package cphy_tx_pkg;

  // Trio wire states: phase x/y/z, polarity +/-
  typedef enum logic [2:0] {PX, NX, PY, NY, PZ, NZ} wire_st_t;

  // Per-wire driver codes
  localparam logic [1:0] HIZ = 2'b00;
  localparam logic [1:0] LO  = 2'b01;
  localparam logic [1:0] HI  = 2'b10;
  localparam logic [1:0] MID = 2'b11;

  typedef enum logic [3:0] {
    ST_STOP,
    ST_HS_RQST,
    ST_BRIDGE,
    ST_PREP,
    ST_PREAMBLE,
    ST_SYNC,
    ST_DATA,
    ST_POST,
    ST_EXIT
  } tx_state_t;

  // LP levels {A,B,C}
  localparam logic [2:0] LP111 = 3'b111;
  localparam logic [2:0] LP001 = 3'b001;
  localparam logic [2:0] LP000 = 3'b000;

  localparam logic [2:0] SYM_PREAMBLE = 3'd3;
  localparam logic [2:0] SYM_POST     = 3'd4;

  // Sync word, first symbol at index 0
  localparam int SYNC_LEN = 7;
  localparam logic [2:0] SYNC_SEQ [SYNC_LEN] = '{3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd3};

  // Driver codes {A,B,C} for a wire state
  function automatic logic [5:0] wire_pupd(input wire_st_t ws);
    case (ws)
      PX:      return {HI,  LO,  MID};
      NX:      return {LO,  HI,  MID};
      PY:      return {MID, HI,  LO };
      NY:      return {MID, LO,  HI };
      PZ:      return {LO,  MID, HI };
      NZ:      return {HI,  MID, LO };
      default: return {HIZ, HIZ, HIZ};
    endcase
  endfunction

endpackage

// File: rtl/cphy_symbol_encoder.sv
// Combinational C-PHY symbol encoder: current wire state + 3-bit symbol
// {Flip,Rot,Pol} -> next wire state and its three driver codes.
// With adv low the current state passes through unchanged.
module cphy_symbol_encoder
  import cphy_tx_pkg::*;
(
  input  wire_st_t   cur_ws,
  input  logic [2:0] sym,
  input  logic       adv,
  output wire_st_t   nxt_ws,
  output logic [1:0] a_pu_pd,
  output logic [1:0] b_pu_pd,
  output logic [1:0] c_pu_pd
);

  logic [1:0] phase;
  logic       neg;
  logic [1:0] nphase;
  logic       nneg;

  // Split state into phase/polarity, apply the symbol, rebuild the state
  always_comb begin
    phase = 2'd0;
    neg   = 1'b0;
    case (cur_ws)
      PX: begin phase = 2'd0; neg = 1'b0; end
      NX: begin phase = 2'd0; neg = 1'b1; end
      PY: begin phase = 2'd1; neg = 1'b0; end
      NY: begin phase = 2'd1; neg = 1'b1; end
      PZ: begin phase = 2'd2; neg = 1'b0; end
      NZ: begin phase = 2'd2; neg = 1'b1; end
      default: ;
    endcase

    nphase = phase;
    nneg   = neg;
    if (adv) begin
      if (sym[2]) begin
        nneg = ~neg;
      end else begin
        if (sym[1]) nphase = (phase == 2'd2) ? 2'd0 : phase + 2'd1;
        else        nphase = (phase == 2'd0) ? 2'd2 : phase - 2'd1;
        nneg = neg ^ sym[0];
      end
    end

    case ({nphase, nneg})
      3'b000:  nxt_ws = PX;
      3'b001:  nxt_ws = NX;
      3'b010:  nxt_ws = PY;
      3'b011:  nxt_ws = NY;
      3'b100:  nxt_ws = PZ;
      3'b101:  nxt_ws = NZ;
      default: nxt_ws = PX;
    endcase

    {a_pu_pd, b_pu_pd, c_pu_pd} = wire_pupd(nxt_ws);
  end

endmodule

// File: rtl/cphy_tx_lane_ctrl.sv
// C-PHY TX lane controller: sequences one trio through LP stop, HS request,
// bridge, prep, preamble, sync, data, post and exit, and drives the analog
// model controls. All outputs are registered.
// Optional macro CPHY_TX_SYM_CNT_EN adds the SymCnt accepted-symbol counter.
module cphy_tx_lane_ctrl
  import cphy_tx_pkg::*;
#(
  parameter int T_LPX        = 4,
  parameter int T_PREP       = 3,
  parameter int PREAMBLE_LEN = 7,
  parameter int POST_LEN     = 7
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       TxReqHs,
  input  logic [2:0] TxSym,
  input  logic       TxSymValid,
  input  logic       TxSymLast,
  output logic       TxSymReady,
  output logic [1:0] A_PU_PD,
  output logic [1:0] B_PU_PD,
  output logic [1:0] C_PU_PD,
  output logic       HsTxEn,
  output logic [2:0] LpTx,
  output logic       LpTxEn,
  output logic       TxBusy,
  output logic       UnderflowErr
`ifdef CPHY_TX_SYM_CNT_EN
  ,
  output logic [15:0] SymCnt
`endif
);

  localparam int MAX_A = (T_LPX > T_PREP) ? T_LPX : T_PREP;
  localparam int MAX_B = (PREAMBLE_LEN > POST_LEN) ? PREAMBLE_LEN : POST_LEN;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_P = (MAX_C > SYNC_LEN) ? MAX_C : SYNC_LEN;
  localparam int CNT_W = $clog2(MAX_P) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  tx_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  wire_st_t         wire_q;

  wire_st_t   enc_cur;
  wire_st_t   enc_nxt;
  logic [2:0] enc_sym;
  logic       enc_adv;
  logic [1:0] enc_a;
  logic [1:0] enc_b;
  logic [1:0] enc_c;
  logic [2:0] sync_idx;
  logic       cnt_last;

  assign cnt_last = (cnt_q == CNT_ONE);

  // Select which symbol (if any) goes out on this edge; BRIDGE seeds +x for PREP
  always_comb begin
    enc_cur  = wire_q;
    enc_sym  = SYM_POST;
    enc_adv  = 1'b0;
    // SYNC entry already sent index 0; count 7..2 maps to indices 1..6
    sync_idx = 3'(CNT_W'(SYNC_LEN + 1) - cnt_q);
    case (state_q)
      ST_BRIDGE: enc_cur = PX;
      ST_PREP: begin
        enc_sym = SYM_PREAMBLE;
        enc_adv = cnt_last;
      end
      ST_PREAMBLE: begin
        enc_sym = cnt_last ? SYNC_SEQ[0] : SYM_PREAMBLE;
        enc_adv = 1'b1;
      end
      ST_SYNC: begin
        if (!cnt_last) enc_sym = SYNC_SEQ[sync_idx];
        enc_adv = !cnt_last;
      end
      ST_DATA: begin
        enc_sym = TxSym;
        enc_adv = TxSymValid;
      end
      ST_POST: enc_adv = (cnt_q != '0);
      default: ;
    endcase
  end

  cphy_symbol_encoder u_enc (
    .cur_ws  (enc_cur),
    .sym     (enc_sym),
    .adv     (enc_adv),
    .nxt_ws  (enc_nxt),
    .a_pu_pd (enc_a),
    .b_pu_pd (enc_b),
    .c_pu_pd (enc_c)
  );

  // Lane FSM with shared down-counter and registered driver controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_STOP;
      cnt_q        <= '0;
      wire_q       <= PX;
      LpTxEn       <= 1'b1;
      LpTx         <= LP111;
      HsTxEn       <= 1'b0;
      A_PU_PD      <= HIZ;
      B_PU_PD      <= HIZ;
      C_PU_PD      <= HIZ;
      TxSymReady   <= 1'b0;
      TxBusy       <= 1'b0;
      UnderflowErr <= 1'b0;
    end else begin
      wire_q <= enc_nxt;
      case (state_q)
        ST_STOP: begin
          if (TxReqHs) begin
            state_q      <= ST_HS_RQST;
            cnt_q        <= CNT_W'(T_LPX);
            LpTx         <= LP001;
            TxBusy       <= 1'b1;
            UnderflowErr <= 1'b0;
          end
        end
        ST_HS_RQST: begin
          if (cnt_last) begin
            state_q <= ST_BRIDGE;
            cnt_q   <= CNT_W'(T_LPX);
            LpTx    <= LP000;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_BRIDGE: begin
          if (cnt_last) begin
            state_q <= ST_PREP;
            cnt_q   <= CNT_W'(T_PREP);
            // LP-to-HS driver swap in one registered update
            LpTxEn  <= 1'b0;
            HsTxEn  <= 1'b1;
            {A_PU_PD, B_PU_PD, C_PU_PD} <= {enc_a, enc_b, enc_c};
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_PREP: begin
          {A_PU_PD, B_PU_PD, C_PU_PD} <= {enc_a, enc_b, enc_c};
          if (cnt_last) begin
            state_q <= ST_PREAMBLE;
            cnt_q   <= CNT_W'(PREAMBLE_LEN);
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_PREAMBLE: begin
          {A_PU_PD, B_PU_PD, C_PU_PD} <= {enc_a, enc_b, enc_c};
          if (cnt_last) begin
            state_q <= ST_SYNC;
            cnt_q   <= CNT_W'(SYNC_LEN);
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_SYNC: begin
          {A_PU_PD, B_PU_PD, C_PU_PD} <= {enc_a, enc_b, enc_c};
          if (cnt_last) begin
            state_q    <= ST_DATA;
            TxSymReady <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_DATA: begin
          {A_PU_PD, B_PU_PD, C_PU_PD} <= {enc_a, enc_b, enc_c};
          // Underflow ends the burst with the wire held for this cycle
          if (!TxSymValid || TxSymLast) begin
            state_q    <= ST_POST;
            cnt_q      <= CNT_W'(POST_LEN);
            TxSymReady <= 1'b0;
            if (!TxSymValid) UnderflowErr <= 1'b1;
          end
        end
        ST_POST: begin
          // First POST cycle still shows the final data state; flips follow
          if (cnt_q != '0) begin
            {A_PU_PD, B_PU_PD, C_PU_PD} <= {enc_a, enc_b, enc_c};
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            state_q <= ST_EXIT;
            HsTxEn  <= 1'b0;
            LpTxEn  <= 1'b1;
            LpTx    <= LP111;
            {A_PU_PD, B_PU_PD, C_PU_PD} <= {HIZ, HIZ, HIZ};
          end
        end
        ST_EXIT: begin
          state_q <= ST_STOP;
          TxBusy  <= 1'b0;
        end
        default: begin
          state_q    <= ST_STOP;
          HsTxEn     <= 1'b0;
          LpTxEn     <= 1'b1;
          LpTx       <= LP111;
          TxSymReady <= 1'b0;
          TxBusy     <= 1'b0;
          {A_PU_PD, B_PU_PD, C_PU_PD} <= {HIZ, HIZ, HIZ};
        end
      endcase
    end
  end

`ifdef CPHY_TX_SYM_CNT_EN
  // Accepted-symbol counter: cleared entering PREAMBLE, saturating, held after burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SymCnt <= 16'd0;
    end else if (state_q == ST_PREP && cnt_last) begin
      SymCnt <= 16'd0;
    end else if (state_q == ST_DATA && TxSymValid && SymCnt != 16'hFFFF) begin
      SymCnt <= SymCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cphy_tx_lane_ctrl.sv
// Directed bench for cphy_tx_lane_ctrl with default parameters.
module tb_cphy_tx_lane_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       TxReqHs = 1'b0;
  logic [2:0] TxSym = 3'd0;
  logic       TxSymValid = 1'b0;
  logic       TxSymLast = 1'b0;
  logic       TxSymReady;
  logic [1:0] A_PU_PD;
  logic [1:0] B_PU_PD;
  logic [1:0] C_PU_PD;
  logic       HsTxEn;
  logic [2:0] LpTx;
  logic       LpTxEn;
  logic       TxBusy;
  logic       UnderflowErr;
`ifdef CPHY_TX_SYM_CNT_EN
  logic [15:0] SymCnt;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  logic excl_on = 1'b0;

  // Hand-written {A,B,C} driver codes per wire state
  localparam logic [5:0] W_PX = 6'b10_01_11;
  localparam logic [5:0] W_NX = 6'b01_10_11;
  localparam logic [5:0] W_PY = 6'b11_10_01;
  localparam logic [5:0] W_NY = 6'b11_01_10;
  localparam logic [5:0] W_PZ = 6'b01_11_10;
  localparam logic [5:0] W_NZ = 6'b10_11_01;

  typedef struct {
    logic [2:0] sym;
    logic       last;
    logic [5:0] exp_w;
    logic       exp_ready;
  } dvec_t;

  dvec_t      walk [5];
  logic [5:0] hs_seq [14];
  int         rdy_cycles;

  cphy_tx_lane_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .TxReqHs      (TxReqHs),
    .TxSym        (TxSym),
    .TxSymValid   (TxSymValid),
    .TxSymLast    (TxSymLast),
    .TxSymReady   (TxSymReady),
    .A_PU_PD      (A_PU_PD),
    .B_PU_PD      (B_PU_PD),
    .C_PU_PD      (C_PU_PD),
    .HsTxEn       (HsTxEn),
    .LpTx         (LpTx),
    .LpTxEn       (LpTxEn),
    .TxBusy       (TxBusy),
    .UnderflowErr (UnderflowErr)
`ifdef CPHY_TX_SYM_CNT_EN
    ,
    .SymCnt       (SymCnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!TxSymReady && n < budget) begin
      step();
      n++;
    end
    chk("wait_ready", {31'd0, TxSymReady}, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (TxBusy && n < budget) begin
      step();
      n++;
    end
    chk("wait_idle", {31'd0, TxBusy}, 32'd0);
  endtask

  // HS and LP drivers must never be enabled together
  always @(negedge clk) begin
    if (excl_on) begin
      n_tests++;
      if (HsTxEn && LpTxEn) begin
        n_fail++;
        $display("FAIL enable_exclusive: HsTxEn=%0b LpTxEn=%0b, both must not be 1", HsTxEn, LpTxEn);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    walk[0] = '{3'd0, 1'b0, W_PZ, 1'b1};
    walk[1] = '{3'd2, 1'b0, W_PX, 1'b1};
    walk[2] = '{3'd1, 1'b0, W_NZ, 1'b1};
    walk[3] = '{3'd4, 1'b0, W_PZ, 1'b1};
    walk[4] = '{3'd7, 1'b1, W_NZ, 1'b0};
    // 7 preamble symbols (3 from +x) then the 7-symbol sync word
    hs_seq = '{W_NY, W_PZ, W_NX, W_PY, W_NZ, W_PX, W_NY,
               W_PZ, W_NZ, W_PZ, W_NZ, W_PZ, W_NZ, W_PX};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lptxen", {31'd0, LpTxEn}, 32'd1);
    chk("rst_lptx", {29'd0, LpTx}, 32'h7);
    chk("rst_hstxen", {31'd0, HsTxEn}, 32'd0);
    chk("rst_pupd", {26'd0, A_PU_PD, B_PU_PD, C_PU_PD}, 32'd0);
    chk("rst_ready", {31'd0, TxSymReady}, 32'd0);
    chk("rst_busy", {31'd0, TxBusy}, 32'd0);
    chk("rst_underflow", {31'd0, UnderflowErr}, 32'd0);
    rst_n   = 1'b1;
    excl_on = 1'b1;
    step();
    chk("idle_busy", {31'd0, TxBusy}, 32'd0);

    // Burst 1: request pulse, LP sequence, prep, preamble, sync, encoder walk
    TxReqHs = 1'b1;
    step();
    TxReqHs = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("hs_rqst_lptx", {29'd0, LpTx}, 32'h1);
      chk("hs_rqst_lpen", {31'd0, LpTxEn}, 32'd1);
      chk("hs_rqst_busy", {31'd0, TxBusy}, 32'd1);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      chk("bridge_lptx", {29'd0, LpTx}, 32'h0);
      chk("bridge_hsen", {31'd0, HsTxEn}, 32'd0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      chk("prep_hsen", {31'd0, HsTxEn}, 32'd1);
      chk("prep_lpen", {31'd0, LpTxEn}, 32'd0);
      chk("prep_pupd", {26'd0, A_PU_PD, B_PU_PD, C_PU_PD}, {26'd0, W_PX});
      step();
    end
    for (int i = 0; i < 14; i++) begin
      chk("pre_sync_pupd", {26'd0, A_PU_PD, B_PU_PD, C_PU_PD}, {26'd0, hs_seq[i]});
      chk("pre_sync_ready", {31'd0, TxSymReady}, 32'd0);
      step();
    end
    chk("data_entry_ready", {31'd0, TxSymReady}, 32'd1);
    chk("data_entry_pupd", {26'd0, A_PU_PD, B_PU_PD, C_PU_PD}, {26'd0, W_PX});
    for (int i = 0; i < 5; i++) begin
      TxSym      = walk[i].sym;
      TxSymValid = 1'b1;
      TxSymLast  = walk[i].last;
      step();
      chk("walk_pupd", {26'd0, A_PU_PD, B_PU_PD, C_PU_PD}, {26'd0, walk[i].exp_w});
      chk("walk_ready", {31'd0, TxSymReady}, {31'd0, walk[i].exp_ready});
    end
    TxSymValid = 1'b0;
    TxSymLast  = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("post_pupd", {26'd0, A_PU_PD, B_PU_PD, C_PU_PD}, {26'd0, (i % 2 == 0) ? W_PZ : W_NZ});
      chk("post_hsen", {31'd0, HsTxEn}, 32'd1);
    end
    step();
    chk("exit_hsen", {31'd0, HsTxEn}, 32'd0);
    chk("exit_lpen", {31'd0, LpTxEn}, 32'd1);
    chk("exit_lptx", {29'd0, LpTx}, 32'h7);
    chk("exit_pupd", {26'd0, A_PU_PD, B_PU_PD, C_PU_PD}, 32'd0);
    chk("exit_busy", {31'd0, TxBusy}, 32'd1);
    step();
    chk("stop_busy", {31'd0, TxBusy}, 32'd0);
    chk("stop_underflow", {31'd0, UnderflowErr}, 32'd0);
`ifdef CPHY_TX_SYM_CNT_EN
    chk("symcnt_5", {16'd0, SymCnt}, 32'd5);
`endif

    // Burst 2: three symbols, Last on the third; Ready must be high 3 cycles
    TxReqHs = 1'b1;
    step();
    TxReqHs = 1'b0;
    wait_ready(40);
    rdy_cycles = 1;
    for (int i = 0; i < 3; i++) begin
      TxSym      = 3'd2;
      TxSymValid = 1'b1;
      TxSymLast  = (i == 2);
      step();
      if (TxSymReady) rdy_cycles++;
      chk("burst3_pupd", {26'd0, A_PU_PD, B_PU_PD, C_PU_PD},
          {26'd0, (i == 0) ? W_PY : ((i == 1) ? W_PZ : W_PX)});
    end
    TxSymValid = 1'b0;
    TxSymLast  = 1'b0;
    wait_idle(30);
    chk("burst3_ready_cycles", rdy_cycles, 32'd3);

    // Burst 3: underflow on the second DATA cycle
    TxReqHs = 1'b1;
    step();
    TxReqHs = 1'b0;
    wait_ready(40);
    TxSym      = 3'd0;
    TxSymValid = 1'b1;
    step();
    chk("uf_first_pupd", {26'd0, A_PU_PD, B_PU_PD, C_PU_PD}, {26'd0, W_PZ});
    chk("uf_not_yet", {31'd0, UnderflowErr}, 32'd0);
    TxSymValid = 1'b0;
    step();
    chk("uf_set", {31'd0, UnderflowErr}, 32'd1);
    chk("uf_ready_low", {31'd0, TxSymReady}, 32'd0);
    chk("uf_wire_held", {26'd0, A_PU_PD, B_PU_PD, C_PU_PD}, {26'd0, W_PZ});
    chk("uf_hsen", {31'd0, HsTxEn}, 32'd1);
    step();
    chk("uf_post_flip", {26'd0, A_PU_PD, B_PU_PD, C_PU_PD}, {26'd0, W_NZ});
    wait_idle(30);
    chk("uf_sticky", {31'd0, UnderflowErr}, 32'd1);
    TxReqHs = 1'b1;
    step();
    TxReqHs = 1'b0;
    chk("uf_cleared", {31'd0, UnderflowErr}, 32'd0);
    chk("uf_req_lptx", {29'd0, LpTx}, 32'h1);

    // Asynchronous reset in the middle of DATA
    wait_ready(40);
    chk("mid_data_hsen", {31'd0, HsTxEn}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_lpen", {31'd0, LpTxEn}, 32'd1);
    chk("async_rst_lptx", {29'd0, LpTx}, 32'h7);
    chk("async_rst_hsen", {31'd0, HsTxEn}, 32'd0);
    chk("async_rst_pupd", {26'd0, A_PU_PD, B_PU_PD, C_PU_PD}, 32'd0);
    chk("async_rst_ready", {31'd0, TxSymReady}, 32'd0);
    chk("async_rst_busy", {31'd0, TxBusy}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", {31'd0, TxBusy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cphy_tx_lane_ctrl.md
Name: cphy_tx_lane_ctrl

Overview:
- Sits directly upstream of the trio analog driver model and generates all of its TX controls: A/B/C_PU_PD, HsTxEn, LpTx and LpTxEn.
- Sequences one C-PHY trio from LP stop through HS request, preamble, sync, data and post, then back to LP stop.
- Encodes a 3-bit symbol stream, one symbol per clock, into wire states.
- Guarantees HsTxEn and LpTxEn are never both high.

Parameters:
- T_LPX, 4: cycles spent in each of HS_RQST and BRIDGE (min 1).
- T_PREP, 3: cycles spent in PREP holding +x (min 1).
- PREAMBLE_LEN, 7: number of symbol-3 repeats in PREAMBLE (min 1).
- POST_LEN, 7: number of symbol-4 repeats in POST (min 1).

Ports:
- clk  in  1  Lane clock; one symbol per cycle.
- rst_n  in  1  Asynchronous active-low reset.
- TxReqHs  in  1  HS burst request; sampled only in STOP.
- TxSym  in  3  Data symbol, bits {Flip,Rot,Pol}.
- TxSymValid  in  1  TxSym valid.
- TxSymLast  in  1  Marks the last data symbol of the burst.
- TxSymReady  out  1  High only in DATA.
- A_PU_PD  out  2  Wire A drive: 00 hi-Z, 01 low, 10 high, 11 mid.
- B_PU_PD  out  2  Wire B drive; same encoding.
- C_PU_PD  out  2  Wire C drive; same encoding.
- HsTxEn  out  1  HS driver enable.
- LpTx  out  3  LP levels {A,B,C}.
- LpTxEn  out  1  LP driver enable.
- TxBusy  out  1  High in any state other than STOP.
- UnderflowErr  out  1  Sticky; cleared on the next accepted TxReqHs.

Behaviour:
- Clock and reset: single clock; reset is asynchronous, active-low.
- Reset values: state STOP; LpTxEn=1, LpTx=111, HsTxEn=0, all PU_PD=00, TxSymReady=0, TxBusy=0, UnderflowErr=0, wire state register=+x.
- Registered outputs: all outputs are registered and reflect the new state from the edge that enters it.
- Wire states (A,B,C):
  - +x = H,L,M; -x = L,H,M
  - +y = M,H,L; -y = M,L,H
  - +z = L,M,H; -z = H,M,L
- Symbol encoding:
  - Flip=1: same phase, opposite polarity; Rot and Pol ignored.
  - Flip=0: Rot=1 rotates CW (x->y->z->x); Rot=0 rotates CCW. Pol=1 inverts polarity.
- STOP: LpTxEn=1, LpTx=111. If TxReqHs=1, go to HS_RQST and clear UnderflowErr.
- HS_RQST: LpTx=001 for T_LPX cycles, then BRIDGE.
- BRIDGE: LpTx=000 for T_LPX cycles, then PREP.
- PREP:
  - On entry, LpTxEn=0, HsTxEn=1, wire state reset to +x.
  - Holds +x for T_PREP cycles, then PREAMBLE.
- PREAMBLE: transmits symbol 3 PREAMBLE_LEN times, then SYNC.
- SYNC: transmits 3,4,4,4,4,4,3 (7 cycles), then DATA.
- DATA:
  - TxSymReady=1.
  - On TxSymValid&TxSymReady: encode TxSym; the new wire state appears on PU_PD at that edge.
  - Accepted TxSymLast goes to POST.
  - TxSymValid=0 in DATA (underflow): no symbol is consumed, wire state is held that cycle, UnderflowErr is set, and the FSM goes to POST.
- POST: transmits symbol 4 POST_LEN times, then EXIT.
- EXIT: one cycle with HsTxEn=0, LpTxEn=1, LpTx=111, PU_PD=00, then STOP.
- LP states: PU_PD=00 in every LP state.
- Enable exclusivity: the HsTxEn/LpTxEn swap happens in a single registered update; both are never high in the same cycle.
- TxReqHs outside STOP: ignored. Dropping it mid-burst does not abort.
- TxSymLast outside DATA: ignored.
- Reset mid-burst: outputs return to reset values immediately, without waiting for a clock.
- Counters: one shared down-counter, width $clog2 of the max parameter plus 1.

Optional Feature:
- Macro: CPHY_TX_SYM_CNT_EN.
- When defined:
  - Adds output SymCnt[15:0] counting accepted DATA symbols.
  - Cleared on PREAMBLE entry; saturates at 0xFFFF.
  - Holds its value after the burst until the next PREAMBLE.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package cphy_tx_pkg holds:
  - Wire-state enum (PX, NX, PY, NY, PZ, NZ).
  - PU_PD code constants (HIZ=00, LO=01, HI=10, MID=11).
  - FSM state enum.
  - LP code constants (LP111, LP001, LP000).
  - Sync sequence constant array.
- Sub-module cphy_symbol_encoder (combinational): inputs current wire state and symbol; outputs next wire state and the three PU_PD codes.

Test Plan:
- Reset with rst_n=0 mid-DATA: LpTxEn=1, LpTx=111, HsTxEn=0, PU_PD=00 immediately.
- TxReqHs pulse with defaults:
  - LpTx=001 for 4 cycles, then 000 for 4 cycles, then HsTxEn=1 with A/B/C=10/01/11 for 3 cycles.
  - First preamble symbol gives -y: A/B/C=11/01/10.
- Encoder walk from +x:
  - symbol 0 -> +z
  - symbol 2 -> +x
  - symbol 1 -> -z
  - symbol 4 -> +z
  - symbol 7 -> -z
- Burst of 3 data symbols with Last on the third:
  - TxSymReady high exactly 3 cycles.
  - Then 7 flips (+/- alternating on the same phase), 1 EXIT cycle, then STOP.
  - TxBusy=0 after EXIT.
- TxSymValid=0 on the 2nd DATA cycle: UnderflowErr=1, POST entered, wire held for that cycle. The next TxReqHs clears UnderflowErr.
- Enable exclusivity, all transitions checked: HsTxEn&LpTxEn is never 1. With CPHY_TX_SYM_CNT_EN defined, a 5-symbol burst gives SymCnt=5.
